// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl
//   Steps the PWM timer through a programmable table of duty values. Each
//   step writes a duty value to the timer, holds it for a programmed number
//   of clocks, then moves to the next step. A sequence can run once or loop.
//
//   Optional build macro:
//     PWM_SEQ_TRIG_EN - after every duty write, issue a software-trigger
//                       command write (addr 3, wdata 2) before the hold.
//
//   Ports:
//     clk_i, rst_i        clock, synchronous active-high reset
//     prog_we_i/idx/duty/hold  table programming (accepted in any state)
//     last_idx_i          last step of the sequence
//     freq_sel_i          frequency selection, latched at start
//     loop_i              wrap to step 0 after the last step
//     start_i, stop_i     start pulse, abort request
//     acc_en_o, wr_en_o, addr_o, wdata_o  registered timer bus write port
//     busy_o              sequence active
//     step_o              current step index
//     done_o              one-cycle pulse on the final write

module pwm_seq_ctrl #(
    parameter int STEPS  = 8,
    parameter int IDX_W  = 3,
    parameter int HOLD_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_we_i,
    input  logic [IDX_W-1:0]  prog_idx_i,
    input  logic [9:0]        prog_duty_i,
    input  logic [HOLD_W-1:0] prog_hold_i,
    input  logic [IDX_W-1:0]  last_idx_i,
    input  logic [1:0]        freq_sel_i,
    input  logic              loop_i,
    input  logic              start_i,
    input  logic              stop_i,
    output logic              acc_en_o,
    output logic              wr_en_o,
    output logic [2:0]        addr_o,
    output logic [15:0]       wdata_o,
    output logic              busy_o,
    output logic [IDX_W-1:0]  step_o,
    output logic              done_o
);

`ifdef PWM_SEQ_TRIG_EN
    typedef enum logic [2:0] {IDLE, CFG, CLR, DUTY, HOLD, FINAL, TRIG} state_t;
`else
    typedef enum logic [2:0] {IDLE, CFG, CLR, DUTY, HOLD, FINAL} state_t;
`endif

    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam logic [2:0] ADDR_DUTY = 3'd1;
    localparam logic [2:0] ADDR_CMD  = 3'd3;

    logic [9:0]        tbl_duty [STEPS];
    logic [HOLD_W-1:0] tbl_hold [STEPS];

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    logic              bus_q;
    logic [2:0]        addr_q;
    logic [15:0]       wdata_q;
    logic              done_q;

    logic              bus_nxt;
    logic [2:0]        addr_nxt;
    logic [15:0]       wdata_nxt;
    logic              done_nxt;
    logic              enter_duty;

    // Bus outputs are registered from the next-state decode, so the write
    // belonging to a state is on the bus during the cycle that state is held.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        hold_nxt   = hold_cnt;
        bus_nxt    = 1'b0;
        addr_nxt   = '0;
        wdata_nxt  = '0;
        done_nxt   = 1'b0;
        enter_duty = 1'b0;

        case (state)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_nxt = CFG;
                    bus_nxt   = 1'b1;
                    addr_nxt  = ADDR_CTRL;
                    wdata_nxt = {14'b0, freq_sel_i};
                end
            end
            CFG: begin
                if (stop_i) begin
                    state_nxt = FINAL;
                end else begin
                    state_nxt = CLR;
                    bus_nxt   = 1'b1;
                    addr_nxt  = ADDR_CMD;
                    wdata_nxt = 16'd1;
                end
            end
            CLR: begin
                if (stop_i) begin
                    state_nxt = FINAL;
                end else begin
                    idx_nxt    = '0;
                    enter_duty = 1'b1;
                end
            end
            DUTY: begin
                if (stop_i) begin
                    state_nxt = FINAL;
                end else begin
`ifdef PWM_SEQ_TRIG_EN
                    state_nxt = TRIG;
                    bus_nxt   = 1'b1;
                    addr_nxt  = ADDR_CMD;
                    wdata_nxt = 16'd2;
`else
                    state_nxt = HOLD;
`endif
                end
            end
`ifdef PWM_SEQ_TRIG_EN
            TRIG: begin
                state_nxt = stop_i ? FINAL : HOLD;
            end
`endif
            HOLD: begin
                if (stop_i) begin
                    state_nxt = FINAL;
                end else if (hold_cnt <= HOLD_W'(1)) begin
                    if (idx < last_idx_i) begin
                        idx_nxt    = idx + IDX_W'(1);
                        enter_duty = 1'b1;
                    end else if (loop_i) begin
                        idx_nxt    = '0;
                        enter_duty = 1'b1;
                    end else begin
                        state_nxt = FINAL;
                    end
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            FINAL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Table entry is read on entry to DUTY; a zero hold counts as one.
        if (enter_duty) begin
            state_nxt = DUTY;
            bus_nxt   = 1'b1;
            addr_nxt  = ADDR_DUTY;
            wdata_nxt = {6'b0, tbl_duty[idx_nxt]};
            hold_nxt  = (tbl_hold[idx_nxt] == '0) ? HOLD_W'(1) : tbl_hold[idx_nxt];
        end

        // FINAL is only ever entered from another state, so this fires once.
        if (state_nxt == FINAL) begin
            bus_nxt   = 1'b1;
            addr_nxt  = ADDR_DUTY;
            wdata_nxt = '0;
            done_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            bus_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            for (int unsigned i = 0; i < STEPS; i++) begin
                tbl_duty[i] <= '0;
                tbl_hold[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            hold_cnt <= hold_nxt;
            bus_q    <= bus_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            done_q   <= done_nxt;
            if (prog_we_i) begin
                tbl_duty[prog_idx_i] <= prog_duty_i;
                tbl_hold[prog_idx_i] <= prog_hold_i;
            end
        end
    end

    assign acc_en_o = bus_q;
    assign wr_en_o  = bus_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign done_o   = done_q;
    assign busy_o   = (state != IDLE);
    assign step_o   = idx;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl - directed bench for pwm_seq_ctrl; expected bus writes are
// queued with the clock they must appear on and matched as they come out.

module tb_pwm_seq_ctrl;

`ifdef PWM_SEQ_TRIG_EN
    localparam int TRIG = 1;
`else
    localparam int TRIG = 0;
`endif
    localparam int NONE = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        prog_we_i = 1'b0;
    logic [2:0]  prog_idx_i = '0;
    logic [9:0]  prog_duty_i = '0;
    logic [15:0] prog_hold_i = '0;
    logic [2:0]  last_idx_i = '0;
    logic [1:0]  freq_sel_i = '0;
    logic        loop_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        acc_en_o, wr_en_o, busy_o, done_o;
    logic [2:0]  addr_o, step_o;
    logic [15:0] wdata_o;

    pwm_seq_ctrl #(.STEPS(8), .IDX_W(3), .HOLD_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .prog_we_i(prog_we_i), .prog_idx_i(prog_idx_i),
        .prog_duty_i(prog_duty_i), .prog_hold_i(prog_hold_i),
        .last_idx_i(last_idx_i), .freq_sel_i(freq_sel_i), .loop_i(loop_i),
        .start_i(start_i), .stop_i(stop_i),
        .acc_en_o(acc_en_o), .wr_en_o(wr_en_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .busy_o(busy_o), .step_o(step_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        done;
        int          cyc;
        bit          step_chk;
        int          step;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  m_duty [8];
    logic [15:0] m_hold [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic [15:0] d, input logic dn,
                        input int c, input bit sc, input int st);
        exp_t e;
        e.addr = a; e.wdata = d; e.done = dn; e.cyc = c; e.step_chk = sc; e.step = st;
        q.push_back(e);
    endtask

    // One clock; every bus cycle is either a queued write or a quiet bus.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (acc_en_o === 1'b1) begin
            chk("pending_write", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_en", 32'(wr_en_o), 32'd1);
                chk("write_cycle", 32'(cyc), 32'(e.cyc));
                chk("addr", 32'(addr_o), 32'(e.addr));
                chk("wdata", 32'(wdata_o), 32'(e.wdata));
                chk("done", 32'(done_o), 32'(e.done));
                if (e.step_chk) chk("step_at_duty", 32'(step_o), 32'(e.step));
            end
        end else begin
            chk("quiet_bus", 32'({wr_en_o, done_o, addr_o, wdata_o}), 32'd0);
        end
    endtask

    task automatic prog(input int i, input int d, input int h);
        prog_we_i   = 1'b1;
        prog_idx_i  = 3'(i);
        prog_duty_i = 10'(d);
        prog_hold_i = 16'(h);
        m_duty[i]   = 10'(d);
        m_hold[i]   = 16'(h);
        tick();
        prog_we_i   = 1'b0;
    endtask

    // Queue the whole write sequence of a run started on edge s; cut is the
    // edge on which stop (or reset) is sampled, fin = a final write follows.
    task automatic plan(input int s, input int last, input bit lp, input int cut,
                        input bit fin, input logic [1:0] fs);
        int t, idx, h;
        push(3'd0, {14'b0, fs}, 1'b0, s, 1'b0, 0);
        push(3'd3, 16'd1, 1'b0, s + 1, 1'b0, 0);
        t = s + 2;
        idx = 0;
        while (t < cut) begin
            push(3'd1, {6'b0, m_duty[idx]}, 1'b0, t, 1'b1, idx);
            if (TRIG == 1 && t + 1 < cut) push(3'd3, 16'd2, 1'b0, t + 1, 1'b0, 0);
            h = (m_hold[idx] == 16'd0) ? 1 : int'(m_hold[idx]);
            t = t + 1 + TRIG + h;
            if (idx < last) idx++;
            else if (lp) idx = 0;
            else break;
        end
        if (fin) push(3'd1, 16'd0, 1'b1, (t < cut) ? t : cut, 1'b0, 0);
    endtask

    task automatic launch(input int last, input bit lp, input logic [1:0] fs);
        last_idx_i = 3'(last);
        loop_i     = lp;
        freq_sel_i = fs;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        freq_sel_i = ~fs;
        chk("busy_running", 32'(busy_o), 32'd1);
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
        chk("missing_writes", 32'(q.size()), 32'd0);
        chk("busy_after", 32'(busy_o), 32'd0);
        q.delete();
    endtask

    int s, hs;

    initial begin
        for (int i = 0; i < 8; i++) begin m_duty[i] = '0; m_hold[i] = '0; end

        // Reset, then a run over the cleared table.
        tick(); tick();
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_step", 32'(step_o), 32'd0);
        chk("reset_acc_en", 32'(acc_en_o), 32'd0);
        rst_i = 1'b0;
        tick();
        s = cyc + 1;
        plan(s, 0, 1'b0, NONE, 1'b1, 2'd2);
        launch(0, 1'b0, 2'd2);
        settle(8);

        // Basic three-step profile.
        prog(0, 102, 4); prog(1, 256, 4); prog(2, 512, 4);
        s = cyc + 1;
        plan(s, 2, 1'b0, NONE, 1'b1, 2'd0);
        launch(2, 1'b0, 2'd0);
        settle(24 + 3 * TRIG);
        chk("step_held_idle", 32'(step_o), 32'd2);

        // Looping for 40 clocks, then stop.
        s = cyc + 1;
        plan(s, 2, 1'b1, s + 40, 1'b1, 2'd3);
        launch(2, 1'b1, 2'd3);
        while (cyc < s + 39) tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        loop_i = 1'b0;
        settle(3);

        // Stop on the second clock of step 1's hold.
        s  = cyc + 1;
        hs = s + 2 + (1 + TRIG + 4) + 1 + TRIG;
        plan(s, 2, 1'b0, hs + 2, 1'b1, 2'd1);
        launch(2, 1'b0, 2'd1);
        while (cyc < hs + 1) tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        settle(3);

        // Start and stop together while idle: nothing happens.
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick(); tick(); tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        settle(2);

        // Zero holds behave as one clock.
        prog(0, 10, 0); prog(1, 20, 0);
        s = cyc + 1;
        plan(s, 1, 1'b0, NONE, 1'b1, 2'd0);
        launch(1, 1'b0, 2'd0);
        settle(10);

        // Entry 1 rewritten while step 0 is holding.
        prog(0, 100, 6); prog(1, 256, 4);
        m_duty[1] = 10'd768;
        s = cyc + 1;
        plan(s, 1, 1'b0, NONE, 1'b1, 2'd1);
        launch(1, 1'b0, 2'd1);
        while (cyc < s + 3) tick();
        prog(1, 768, 4);
        settle(16);

        // Reset in the middle of a hold: no final write, table cleared.
        prog(0, 50, 8);
        s = cyc + 1;
        plan(s, 0, 1'b0, s + 6, 1'b0, 2'd0);
        launch(0, 1'b0, 2'd0);
        while (cyc < s + 5) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midreset_busy", 32'(busy_o), 32'd0);
        chk("midreset_step", 32'(step_o), 32'd0);
        for (int i = 0; i < 8; i++) begin m_duty[i] = '0; m_hold[i] = '0; end
        settle(4);
        s = cyc + 1;
        plan(s, 0, 1'b0, NONE, 1'b1, 2'd3);
        launch(0, 1'b0, 2'd3);
        settle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
- Sequencer that drives the PWM timer's register bus (acc_en/wr_en/addr/wdata) through a programmable table of duty-cycle steps.
- Each step writes a duty value, holds it for a programmed number of clocks, then advances.
- Replaces manual bus writes when software or a host needs timed duty profiles: soft-start, ramps, and repeating patterns.
- Sits between the host/config logic and the PWM timer's bus slave port. Single clock domain.

Parameters:
STEPS, 8, number of table entries (power of 2, 2..16)
IDX_W, 3, log2(STEPS)
HOLD_W, 16, width of per-step hold counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
prog_we_i  in  1  table write strobe
prog_idx_i  in  IDX_W  table entry index
prog_duty_i  in  10  duty value for entry
prog_hold_i  in  HOLD_W  hold length in clocks for entry
last_idx_i  in  IDX_W  last step index of the sequence
freq_sel_i  in  2  timer frequency selection written at sequence start
loop_i  in  1  1 = wrap to step 0 after last step
start_i  in  1  start pulse
stop_i  in  1  abort request
acc_en_o  out  1  timer bus access enable
wr_en_o  out  1  timer bus write enable
addr_o  out  3  timer register address
wdata_o  out  16  timer write data
busy_o  out  1  sequence active
step_o  out  IDX_W  current step index
done_o  out  1  one-cycle pulse on sequence end

Behaviour:
- Reset: clk_i rising edge with rst_i=1. All outputs go to 0, FSM goes to IDLE, and all table entries are cleared to duty=0, hold=0. Reset mid-sequence aborts immediately with no final bus write.
- Timer register map driven by this block:
  - addr 0: control; wdata[1:0] = freq_sel, other bits 0.
  - addr 1: duty; wdata = {6'b0, duty}.
  - addr 3: command; bit0 = clear, bit1 = SW trigger.
- Bus writes:
  - acc_en_o=wr_en_o=1 for exactly one clock per write, with addr_o/wdata_o valid in that same clock. Outputs are registered.
  - Outside writes, acc_en_o=wr_en_o=0 and addr_o/wdata_o=0.
  - The timer accepts a write every clock, with no wait states.
- Table: prog_we_i writes entry prog_idx_i in any state. An entry is read when its DUTY state is entered, so edits during a run take effect on the next visit to that entry.
- FSM states: IDLE, CFG, CLR, DUTY, HOLD, FINAL.
  - IDLE: busy_o=0. start_i=1 and stop_i=0 -> CFG.
  - CFG: write addr 0 with freq_sel_i, latched at start. -> CLR.
  - CLR: write addr 3, wdata=1. -> DUTY, idx=0.
  - DUTY: write addr 1 with table[idx].duty; load the hold counter with max(hold,1). -> HOLD.
  - HOLD: decrement once per clock. On expiry:
    - idx<last_idx -> idx+1, DUTY.
    - idx==last_idx and loop_i=1 -> idx=0, DUTY.
    - otherwise -> FINAL.
  - FINAL: write addr 1, wdata=0; done_o=1 in this cycle. -> IDLE.
- Latency: the first write (CFG) appears the clock after start_i is sampled. The first duty write comes 3 clocks after start is sampled. Consecutive duty writes are 1+max(hold,1) clocks apart.
- hold=0 is treated as 1.
- last_idx_i and loop_i are sampled at each HOLD expiry.
- busy_o=1 in all states except IDLE. step_o = current idx, and holds its last value in IDLE.
- stop_i: in any non-IDLE, non-FINAL state, stop_i -> FINAL next clock. The current state's write, if any, still completes.
- start_i while busy is ignored. start_i and stop_i together in IDLE: stop wins, so it stays IDLE.

Optional Feature:
PWM_SEQ_TRIG_EN:
- Defined: each DUTY write is followed by one extra clock (TRIG state) writing addr 3, wdata=2 (SW trigger). HOLD starts after TRIG, so duty-write spacing becomes 2+max(hold,1).
- Undefined: the TRIG state is absent and no command writes occur except in CLR.

Test Plan:
- Reset check: rst_i high for 2 clocks, then low -> all outputs 0, busy_o=0, and a read of entry 0 by start with last_idx=0 produces duty write wdata=0.
- Basic run: table {102/hold 4, 256/4, 512/4}, last_idx=2, freq_sel=0, loop=0, pulse start. Expected:
  - bus sequence (0,0x0000), (3,0x0001), (1,102), (1,256), (1,512), (1,0)
  - duty writes 5 clocks apart
  - done_o pulse coincides with the final write, then busy_o=0.
- Loop: same table with loop=1, run for 40 clocks -> duty writes cycle 102,256,512,102,... with step_o wrapping 2->0 and no done_o.
- Stop mid-hold: assert stop_i at clock 2 of step 1's hold -> next clock writes (1,0) with done_o=1, then IDLE. Raise start and stop together in IDLE -> no bus activity.
- Boundaries: hold=0 entry -> writes 2 clocks apart. Reprogram entry 1 to 768 while running step 0 -> step 1 writes 768. Assert rst_i mid-HOLD -> outputs 0 next clock with no final write.
- PWM_SEQ_TRIG_EN build: basic run -> each (1,duty) is immediately followed by (3,0x0002), and duty spacing is 6 clocks.
